voice_allocator: RTL and testbench
==================================

// Module: voice_allocator
// PURPOSE
//  Bus-master scheduler that shares NUM_VOICES wave-generator voices among incoming note events.
//  Accepts note-on/off requests, picks a voice (match > free > oldest-steal) and issues register
//  writes (incr, gate) to the per-voice wave-gen controllers over the 16-bit address / 8-bit data bus.
//  Sits between the note source (keyboard/sequencer front end) and the wave-gen controller bank.
// PARAMETERS
//  NUM_VOICES    4        voices managed; voice v lives at BASE_ADDR + v*VOICE_STRIDE
//  BASE_ADDR     16'h0000 bus address of voice 0 register block
//  VOICE_STRIDE  4        address span per voice (regs: +0 incr, +1 gate, +2 wavetype, +3 pulsewidth)
//  WAVE_DEPTH    8        width of NoteIncr; written as the low 8 bits of BusDataOut, zero-extended if < 8
// PORTS
//  Clock         in   1           system clock; all state on posedge
//  Reset         in   1           synchronous, active-low reset
//  NoteValid     in   1           request present
//  NoteReady     out  1           block can accept; transfer when NoteValid && NoteReady
//  NoteOn        in   1           1 = note-on, 0 = note-off
//  NoteNum       in   7           note number (tag for match/release)
//  NoteIncr      in   WAVE_DEPTH  phase increment for note-on
//  BusAddress    out  16          bus address
//  BusDataOut    out  8           write data (top level drives shared BusData from this while BusReadWrite=1)
//  BusReadWrite  out  1           1 = write; held 1 at all times (block never reads)
//  BusClock      out  1           bus strobe; slaves sample on its rising edge
//  ActiveMask    out  NUM_VOICES  bit v = voice v gate open
//  Busy          out  1           ~NoteReady
// BEHAVIOUR
//  Reset (Reset==0 at posedge): NoteReady=0 during reset, 1 first cycle after; BusAddress=0, BusDataOut=0,
//   BusReadWrite=1, BusClock=0, ActiveMask=0, Busy=1 during reset; voice table (valid, note, age) cleared.
//   Reset asserted mid-transaction aborts it: BusClock forced 0 on that edge, no further strobes.
//  FSM: IDLE -> LOOKUP -> {WR_OFF} -> {WR_INCR -> WR_GATE} -> IDLE. NoteReady=1 only in IDLE.
//  Accept (cycle T): latch NoteOn/NoteNum/NoteIncr; go LOOKUP at T+1 (one cycle, decision registered).
//  Voice choice, note-on: (1) valid voice with same NoteNum (retrigger, no WR_OFF);
//   (2) else lowest-index free voice; (3) else steal voice with highest age, ties -> lowest index,
//   preceded by WR_OFF (gate=0) to that voice.
//  Note-on: WR_INCR writes NoteIncr to +0, WR_GATE writes 8'h01 to +1; voice valid=1, note=NoteNum, age=0;
//   every other valid voice age += 1, saturating at 255. Age updated in LOOKUP.
//  Note-off: match valid voice with NoteNum -> WR_OFF writes 8'h00 to +1, voice valid=0, age=0.
//   No match -> no bus traffic, LOOKUP -> IDLE.
//  Bus write = 3 cycles: SETUP (addr/data valid, BusClock=0), STROBE (BusClock=1), HOLD (BusClock=0,
//   addr/data unchanged). BusClock high exactly 1 cycle per write; addr/data stable 1 cycle before and after.
//  Between writes / in IDLE: BusClock=0, BusReadWrite=1, BusAddress/BusDataOut hold last values.
//  Latency from accept T to NoteReady=1: note-on free/retrigger T+8; steal T+11; note-off hit T+5; miss T+2.
//  ActiveMask updates in LOOKUP (before bus writes complete). Address arithmetic 16-bit, wraps mod 2^16.
//  NoteValid while NoteReady=0: ignored, request held upstream; no internal queue.
// STRUCTURE
//  synth_pkg: register offsets (REG_INCR=0, REG_GATE=1, REG_WAVE=2, REG_PW=3), gate data constants,
//   FSM state encoding, bus write cycle phases.
//  Sub-module voice_select: combinational match/free/oldest search over voice table, outputs index + hit flags.
// TESTING
//  Reset low 3 cycles mid-WR_GATE strobe -> BusClock 0 next edge, ActiveMask=0, NoteReady=1 after release.
//  Note-on 60 incr 8'h10, idle table -> writes (0x0000,0x10),(0x0001,0x01); NoteReady at T+8; ActiveMask=0001.
//  Note-ons 60,62,64,67 then 69 -> 69 steals voice 0: writes (0x0001,0x00),(0x0000,incr),(0x0001,0x01).
//  Note-on 62 again while held on voice 1 -> only (0x0005 incr),(0x0005... no: (0x0004,incr),(0x0005,0x01), no WR_OFF.
//  Note-off 64 (voice 2) -> single write (0x0009,0x00), ActiveMask bit2=0; note-off 50 -> no BusClock, ready T+2.
//  Every write: BusReadWrite=1, one-cycle BusClock pulse, address/data stable around strobe (assertion).

Source files
------------

// File: rtl/voice_allocator_pkg.sv
// Shared constants for the voice allocator: register offsets, gate values,
// FSM state encoding and bus write phases.
package voice_allocator_pkg;

  localparam int AGE_W = 8;

  typedef enum logic [1:0] {
    REG_INCR = 2'd0,
    REG_GATE = 2'd1,
    REG_WAVE = 2'd2,
    REG_PW   = 2'd3
  } reg_off_e;

  localparam logic [7:0] GATE_ON  = 8'h01;
  localparam logic [7:0] GATE_OFF = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_WR_OFF,
    ST_WR_INCR,
    ST_WR_GATE
  } state_e;

  typedef enum logic [1:0] {
    PH_SETUP,
    PH_STROBE,
    PH_HOLD
  } phase_e;

  function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
    return (a == {AGE_W{1'b1}}) ? a : a + 1'b1;
  endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Note request channel plus the wave-gen register write bus of the voice allocator.
interface voice_allocator_if #(
  parameter int NUM_VOICES = 4,
  parameter int WAVE_DEPTH = 8
);
  logic                  NoteValid;
  logic                  NoteReady;
  logic                  NoteOn;
  logic [6:0]            NoteNum;
  logic [WAVE_DEPTH-1:0] NoteIncr;
  logic [15:0]           BusAddress;
  logic [7:0]            BusDataOut;
  logic                  BusReadWrite;
  logic                  BusClock;
  logic [NUM_VOICES-1:0] ActiveMask;
  logic                  Busy;

  modport master (
    input  NoteValid, NoteOn, NoteNum, NoteIncr,
    output NoteReady, BusAddress, BusDataOut, BusReadWrite, BusClock, ActiveMask, Busy
  );

  modport slave (
    output NoteValid, NoteOn, NoteNum, NoteIncr,
    input  NoteReady, BusAddress, BusDataOut, BusReadWrite, BusClock, ActiveMask, Busy
  );
endinterface

// File: rtl/voice_allocator_voice_select.sv
// Combinational search over the voice table: note match, lowest free voice,
// and oldest valid voice (ties resolved toward the lowest index).
module voice_select #(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = 2,
  parameter int AGE_W      = 8
) (
  input  logic [NUM_VOICES-1:0]            valid_i,
  input  logic [NUM_VOICES-1:0][6:0]       note_i,
  input  logic [NUM_VOICES-1:0][AGE_W-1:0] age_i,
  input  logic [6:0]                       key_i,
  output logic                             match_o,
  output logic [IDX_W-1:0]                 match_idx_o,
  output logic                             free_o,
  output logic [IDX_W-1:0]                 free_idx_o,
  output logic [IDX_W-1:0]                 oldest_idx_o
);

  logic [AGE_W-1:0] best_age;
  logic             found;

  always_comb begin
    match_o      = 1'b0;
    match_idx_o  = '0;
    free_o       = 1'b0;
    free_idx_o   = '0;
    oldest_idx_o = '0;
    best_age     = '0;
    found        = 1'b0;
    // Descending scan so the lowest index is the last (winning) assignment.
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (valid_i[v] && (note_i[v] == key_i)) begin
        match_o     = 1'b1;
        match_idx_o = IDX_W'(v);
      end
      if (!valid_i[v]) begin
        free_o     = 1'b1;
        free_idx_o = IDX_W'(v);
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (valid_i[v] && (!found || (age_i[v] > best_age))) begin
        found        = 1'b1;
        best_age     = age_i[v];
        oldest_idx_o = IDX_W'(v);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Voice allocator: assigns note events to wave-gen voices (match > free > steal oldest)
// and programs them with 3-cycle register writes (setup / strobe / hold).
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int          NUM_VOICES   = 4,
  parameter logic [15:0] BASE_ADDR    = 16'h0000,
  parameter int          VOICE_STRIDE = 4,
  parameter int          WAVE_DEPTH   = 8
) (
  input logic               Clock,
  input logic               Reset,
  voice_allocator_if.master bus
);

  localparam int IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int INCR_EXT_W = (WAVE_DEPTH > 8) ? WAVE_DEPTH : 8;

  state_e                           state_q, state_d;
  phase_e                           phase_q, phase_d;
  logic [NUM_VOICES-1:0]            valid_q, valid_d;
  logic [NUM_VOICES-1:0][6:0]       note_q, note_d;
  logic [NUM_VOICES-1:0][AGE_W-1:0] age_q, age_d;
  logic [15:0]                      bus_addr_q, bus_addr_d;
  logic [7:0]                       bus_data_q, bus_data_d;
  logic                             bus_clk_q, bus_clk_d;

  logic                             on_q, on_d;
  logic [6:0]                       num_q, num_d;
  logic [WAVE_DEPTH-1:0]            incr_q, incr_d;
  logic [IDX_W-1:0]                 tgt_q, tgt_d;

  logic                             match_hit, free_hit;
  logic [IDX_W-1:0]                 match_idx, free_idx, oldest_idx, sel;
  logic [INCR_EXT_W-1:0]            incr_ext;
  logic [7:0]                       incr_byte;

  function automatic logic [15:0] reg_addr(input logic [IDX_W-1:0] v, input reg_off_e off);
    return BASE_ADDR + (16'(v) * 16'(VOICE_STRIDE)) + 16'(off);
  endfunction

  assign incr_ext  = INCR_EXT_W'(incr_q);
  assign incr_byte = incr_ext[7:0];

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .IDX_W      (IDX_W),
    .AGE_W      (AGE_W)
  ) u_select (
    .valid_i      (valid_q),
    .note_i       (note_q),
    .age_i        (age_q),
    .key_i        (num_q),
    .match_o      (match_hit),
    .match_idx_o  (match_idx),
    .free_o       (free_hit),
    .free_idx_o   (free_idx),
    .oldest_idx_o (oldest_idx)
  );

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    valid_d    = valid_q;
    note_d     = note_q;
    age_d      = age_q;
    bus_addr_d = bus_addr_q;
    bus_data_d = bus_data_q;
    on_d       = on_q;
    num_d      = num_q;
    incr_d     = incr_q;
    tgt_d      = tgt_q;
    sel        = match_hit ? match_idx : (free_hit ? free_idx : oldest_idx);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.NoteValid) begin
          on_d    = bus.NoteOn;
          num_d   = bus.NoteNum;
          incr_d  = bus.NoteIncr;
          state_d = ST_LOOKUP;
        end
      end

      ST_LOOKUP: begin
        phase_d = PH_SETUP;
        if (on_q) begin
          tgt_d = sel;
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (valid_q[v]) age_d[v] = age_inc(age_q[v]);
          end
          valid_d[sel] = 1'b1;
          note_d[sel]  = num_q;
          age_d[sel]   = '0;
          if (!match_hit && !free_hit) begin
            state_d    = ST_WR_OFF;
            bus_addr_d = reg_addr(sel, REG_GATE);
            bus_data_d = GATE_OFF;
          end else begin
            state_d    = ST_WR_INCR;
            bus_addr_d = reg_addr(sel, REG_INCR);
            bus_data_d = incr_byte;
          end
        end else if (match_hit) begin
          tgt_d              = match_idx;
          valid_d[match_idx] = 1'b0;
          age_d[match_idx]   = '0;
          state_d            = ST_WR_OFF;
          bus_addr_d         = reg_addr(match_idx, REG_GATE);
          bus_data_d         = GATE_OFF;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WR_OFF, ST_WR_INCR, ST_WR_GATE: begin
        unique case (phase_q)
          PH_SETUP:  phase_d = PH_STROBE;
          PH_STROBE: phase_d = PH_HOLD;
          default: begin
            phase_d = PH_SETUP;
            if (state_q == ST_WR_OFF && on_q) begin
              state_d    = ST_WR_INCR;
              bus_addr_d = reg_addr(tgt_q, REG_INCR);
              bus_data_d = incr_byte;
            end else if (state_q == ST_WR_INCR) begin
              state_d    = ST_WR_GATE;
              bus_addr_d = reg_addr(tgt_q, REG_GATE);
              bus_data_d = GATE_ON;
            end else begin
              state_d = ST_IDLE;
            end
          end
        endcase
      end

      default: state_d = ST_IDLE;
    endcase

    // Strobe is registered so BusClock is glitch-free and sits mid-write.
    bus_clk_d = (phase_d == PH_STROBE);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_SETUP;
      valid_q    <= '0;
      note_q     <= '0;
      age_q      <= '0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      bus_clk_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      valid_q    <= valid_d;
      note_q     <= note_d;
      age_q      <= age_d;
      bus_addr_q <= bus_addr_d;
      bus_data_q <= bus_data_d;
      bus_clk_q  <= bus_clk_d;
    end
  end

  always_ff @(posedge Clock) begin
    on_q   <= on_d;
    num_q  <= num_d;
    incr_q <= incr_d;
    tgt_q  <= tgt_d;
  end

  assign bus.NoteReady    = Reset && (state_q == ST_IDLE);
  assign bus.Busy         = ~bus.NoteReady;
  assign bus.BusReadWrite = 1'b1;
  assign bus.BusClock     = bus_clk_q;
  assign bus.BusAddress   = bus_addr_q;
  assign bus.BusDataOut   = bus_data_q;
  assign bus.ActiveMask   = valid_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed vector table, reset-during-strobe sequence,
// and random note traffic against a timestamp-based voice model.
module tb_voice_allocator;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  voice_allocator_if #(.NUM_VOICES(4), .WAVE_DEPTH(8)) ifc ();

  voice_allocator #(
    .NUM_VOICES   (4),
    .BASE_ADDR    (16'h0000),
    .VOICE_STRIDE (4),
    .WAVE_DEPTH   (8)
  ) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (ifc.master)
  );

  typedef struct packed {
    logic        on;
    logic [6:0]  num;
    logic [7:0]  incr;
    int          lat;
    int          nwr;
    logic [15:0] a0; logic [7:0] d0;
    logic [15:0] a1; logic [7:0] d1;
    logic [15:0] a2; logic [7:0] d2;
    logic [3:0]  mask;
  } vec_t;

  logic [15:0] cap_a[$];
  logic [7:0]  cap_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bus monitor: captures strobed writes and checks the write framing.
  logic        prev_clk = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [7:0]  prev_data = '0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("rw_high", ifc.BusReadWrite, 1);
      if (ifc.BusClock) begin
        cap_a.push_back(ifc.BusAddress);
        cap_d.push_back(ifc.BusDataOut);
        chk("strobe_one_cycle", prev_clk, 0);
        chk("setup_addr", ifc.BusAddress, prev_addr);
        chk("setup_data", ifc.BusDataOut, prev_data);
      end else if (prev_clk) begin
        chk("hold_addr", ifc.BusAddress, prev_addr);
        chk("hold_data", ifc.BusDataOut, prev_data);
      end
    end
    prev_clk  = ifc.BusClock;
    prev_addr = ifc.BusAddress;
    prev_data = ifc.BusDataOut;
  end

  function automatic vec_t mk(input logic on, input logic [6:0] num, input logic [7:0] incr,
                              input int lat, input int nwr,
                              input logic [15:0] a0, input logic [7:0] d0,
                              input logic [15:0] a1, input logic [7:0] d1,
                              input logic [15:0] a2, input logic [7:0] d2,
                              input logic [3:0] mask);
    vec_t v;
    v.on = on; v.num = num; v.incr = incr; v.lat = lat; v.nwr = nwr;
    v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1; v.a2 = a2; v.d2 = d2;
    v.mask = mask;
    return v;
  endfunction

  task automatic send(input logic on, input logic [6:0] num, input logic [7:0] incr,
                      output int lat, output logic [3:0] mid_mask);
    int n;
    n = 0;
    while (ifc.NoteReady !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_send", ifc.NoteReady, 1);
    cap_a.delete();
    cap_d.delete();
    ifc.NoteOn    = on;
    ifc.NoteNum   = num;
    ifc.NoteIncr  = incr;
    ifc.NoteValid = 1'b1;
    @(posedge clk);
    #1 ifc.NoteValid = 1'b0;
    lat      = 0;
    mid_mask = 'x;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 2) mid_mask = ifc.ActiveMask;
      if (ifc.NoteReady === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic apply_and_check(input string tag, input vec_t e);
    int         lat;
    logic [3:0] mid;
    logic [15:0] ea[3];
    logic [7:0]  ed[3];
    send(e.on, e.num, e.incr, lat, mid);
    ea[0] = e.a0; ea[1] = e.a1; ea[2] = e.a2;
    ed[0] = e.d0; ed[1] = e.d1; ed[2] = e.d2;
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_nwrites"}, cap_a.size(), e.nwr);
    for (int i = 0; i < e.nwr && i < 3; i++) begin
      chk({tag, "_addr"}, (i < cap_a.size()) ? 32'(cap_a[i]) : 32'hDEAD_BEEF, ea[i]);
      chk({tag, "_data"}, (i < cap_d.size()) ? 32'(cap_d[i]) : 32'hDEAD_BEEF, ed[i]);
    end
    chk({tag, "_mask_lookup"}, mid, e.mask);
    chk({tag, "_mask_final"}, ifc.ActiveMask, e.mask);
  endtask

  // Reference model: a voice's age is the number of note-ons since it was last
  // triggered (capped at 255), tracked as a trigger timestamp.
  bit         m_valid[4];
  logic [6:0] m_note[4];
  int         m_stamp[4];
  int         on_count;

  function automatic int m_age(input int v);
    int a;
    a = on_count - m_stamp[v];
    return (a > 255) ? 255 : a;
  endfunction

  task automatic model_reset();
    for (int v = 0; v < 4; v++) begin
      m_valid[v] = 0; m_note[v] = '0; m_stamp[v] = 0;
    end
    on_count = 0;
  endtask

  task automatic model_step(input logic on, input logic [6:0] num, input logic [7:0] incr,
                            output vec_t e);
    int hit, fr, old, best, v;
    hit = -1; fr = -1; old = 0; best = -1;
    for (int i = 3; i >= 0; i--) begin
      if (m_valid[i] && m_note[i] == num) hit = i;
      if (!m_valid[i]) fr = i;
    end
    for (int i = 0; i < 4; i++)
      if (m_valid[i] && m_age(i) > best) begin best = m_age(i); old = i; end
    e = mk(on, num, incr, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    if (on) begin
      v = (hit >= 0) ? hit : ((fr >= 0) ? fr : old);
      if (hit < 0 && fr < 0) begin
        e.lat = 11; e.nwr = 3;
        e.a0 = 16'(v * 4 + 1); e.d0 = 8'h00;
        e.a1 = 16'(v * 4);     e.d1 = incr;
        e.a2 = 16'(v * 4 + 1); e.d2 = 8'h01;
      end else begin
        e.lat = 8; e.nwr = 2;
        e.a0 = 16'(v * 4);     e.d0 = incr;
        e.a1 = 16'(v * 4 + 1); e.d1 = 8'h01;
      end
      on_count++;
      m_valid[v] = 1; m_note[v] = num; m_stamp[v] = on_count;
    end else if (hit >= 0) begin
      e.lat = 5; e.nwr = 1;
      e.a0 = 16'(hit * 4 + 1); e.d0 = 8'h00;
      m_valid[hit] = 0;
    end
    for (int i = 0; i < 4; i++) e.mask[i] = m_valid[i];
  endtask

  vec_t vecs[10];

  initial begin
    vec_t e;
    int   n;

    vecs[0] = mk(1, 60, 8'h10,  8, 2, 16'h0, 8'h10, 16'h1, 8'h01, 0, 0, 4'b0001);
    vecs[1] = mk(1, 62, 8'h20,  8, 2, 16'h4, 8'h20, 16'h5, 8'h01, 0, 0, 4'b0011);
    vecs[2] = mk(1, 64, 8'h30,  8, 2, 16'h8, 8'h30, 16'h9, 8'h01, 0, 0, 4'b0111);
    vecs[3] = mk(1, 67, 8'h40,  8, 2, 16'hC, 8'h40, 16'hD, 8'h01, 0, 0, 4'b1111);
    vecs[4] = mk(1, 69, 8'h50, 11, 3, 16'h1, 8'h00, 16'h0, 8'h50, 16'h1, 8'h01, 4'b1111);
    vecs[5] = mk(1, 62, 8'h22,  8, 2, 16'h4, 8'h22, 16'h5, 8'h01, 0, 0, 4'b1111);
    vecs[6] = mk(0, 64, 8'h00,  5, 1, 16'h9, 8'h00, 0, 0, 0, 0, 4'b1011);
    vecs[7] = mk(0, 50, 8'h00,  2, 0, 0, 0, 0, 0, 0, 0, 4'b1011);
    vecs[8] = mk(1, 70, 8'h70,  8, 2, 16'h8, 8'h70, 16'h9, 8'h01, 0, 0, 4'b1111);
    vecs[9] = mk(1, 72, 8'h72, 11, 3, 16'hD, 8'h00, 16'hC, 8'h72, 16'hD, 8'h01, 4'b1111);

    rst_n = 1'b0;
    ifc.NoteValid = 1'b0;
    ifc.NoteOn    = 1'b0;
    ifc.NoteNum   = '0;
    ifc.NoteIncr  = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", ifc.NoteReady, 0);
    chk("rst_busy", ifc.Busy, 1);
    chk("rst_addr", ifc.BusAddress, 0);
    chk("rst_data", ifc.BusDataOut, 0);
    chk("rst_rw", ifc.BusReadWrite, 1);
    chk("rst_busclk", ifc.BusClock, 0);
    chk("rst_mask", ifc.ActiveMask, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", ifc.NoteReady, 1);
    chk("post_rst_busy", ifc.Busy, 0);

    for (int i = 0; i < 10; i++) apply_and_check($sformatf("vec%0d", i), vecs[i]);

    // Reset during the gate-on strobe of a steal sequence.
    ifc.NoteOn = 1'b1; ifc.NoteNum = 7'd10; ifc.NoteIncr = 8'h33; ifc.NoteValid = 1'b1;
    @(posedge clk);
    #1 ifc.NoteValid = 1'b0;
    n = 0;
    while (!(ifc.BusClock === 1'b1 && ifc.BusDataOut === 8'h01) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("gate_strobe_seen", (n < 20), 1);
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_busclk", ifc.BusClock, 0);
      chk("midrst_mask", ifc.ActiveMask, 0);
      chk("midrst_ready", ifc.NoteReady, 0);
      chk("midrst_busy", ifc.Busy, 1);
      chk("midrst_addr", ifc.BusAddress, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_release_ready", ifc.NoteReady, 1);
    chk("midrst_release_mask", ifc.ActiveMask, 0);
    chk("midrst_release_busclk", ifc.BusClock, 0);

    model_reset();
    for (int i = 0; i < 80; i++) begin
      logic       on;
      logic [6:0] num;
      logic [7:0] incr;
      on   = ($urandom_range(0, 9) < 6);
      num  = 7'(40 + $urandom_range(0, 5));
      incr = 8'($urandom);
      model_step(on, num, incr, e);
      apply_and_check($sformatf("rnd%0d", i), e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
